multi_tick_gen: RTL

- Parametrised, multi-channel successor to the single fixed-rate tick divider.
- Each of NUM_CH channels divides clk by a runtime-programmable divisor and produces a one-cycle tick pulse plus a near-50% square wave.
- Divisors are reprogrammed over a valid/ready config port; updates take effect glitch-free at the channel's next wrap.
- Sits beside the system clock as the timebase source for display refresh, debouncers and 1 Hz/1 kHz housekeeping.

---
 rtl/multi_tick_gen.sv | 130 +++++++++++++
 1 files changed

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick divider: per-channel one-cycle tick and near-50% square wave,
// with divisors reprogrammed through a single-slot valid/ready config port.
module multi_tick_gen #(
  parameter  int unsigned NUM_CH      = 4,
  parameter  int unsigned CNT_W       = 27,
  parameter  int unsigned DEFAULT_DIV = 100000,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_div_i,
  output logic              cfg_err_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] sq_o
);

  localparam int unsigned CH_SLOTS = 1 << CH_W;
  // One bit per encodable channel index; set where the index names a real channel.
  localparam logic [CH_SLOTS-1:0] CH_VALID = {CH_SLOTS{1'b1}} >> (CH_SLOTS - NUM_CH);

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sq_q, sq_d;
  logic              pend_q, pend_d;
  logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
  logic [CNT_W-1:0]  pend_div_q, pend_div_d;
  logic              cfg_err_q, cfg_err_d;
  logic              cfg_ready_q, cfg_ready_d;

  logic [NUM_CH-1:0] wrap_s;
  logic [NUM_CH-1:0] upd_s;

  // Wrap is ">=" so a count left above a freshly shrunk divisor still wraps next enabled cycle.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wrap_s[i] = en_i[i] && (cnt_q[i] >= (div_q[i] - CNT_W'(1)));
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      upd_s[i] = pend_q && (pend_ch_q == CH_W'(i)) && (sync_i || !en_i[i] || wrap_s[i]);
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    div_d       = div_q;
    tick_d      = '0;
    sq_d        = sq_q;
    pend_d      = pend_q;
    pend_ch_d   = pend_ch_q;
    pend_div_d  = pend_div_q;
    cfg_err_d   = 1'b0;
    cfg_ready_d = cfg_ready_q;

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (upd_s[i]) begin
        div_d[i] = pend_div_q;
      end
      // sq follows the count about to be loaded, measured against the divisor now in force.
      if (sync_i) begin
        cnt_d[i] = '0;
        sq_d[i]  = div_d[i] > CNT_W'(1);
      end else if (en_i[i]) begin
        if (wrap_s[i]) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          sq_d[i]   = div_d[i] > CNT_W'(1);
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
          sq_d[i]  = (cnt_q[i] + CNT_W'(1)) < (div_q[i] >> 1);
        end
      end
    end

    if (|upd_s) begin
      pend_d = 1'b0;
    end else if (cfg_valid_i && cfg_ready_q) begin
      if ((cfg_div_i == '0) || !CH_VALID[cfg_ch_i]) begin
        cfg_err_d = 1'b1;
      end else begin
        pend_d     = 1'b1;
        pend_ch_d  = cfg_ch_i;
        pend_div_d = cfg_div_i;
      end
    end
    cfg_ready_d = !pend_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= CNT_W'(DEFAULT_DIV);
      end
      tick_q      <= '0;
      sq_q        <= '0;
      pend_q      <= 1'b0;
      pend_ch_q   <= '0;
      pend_div_q  <= '0;
      cfg_err_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      sq_q        <= sq_d;
      pend_q      <= pend_d;
      pend_ch_q   <= pend_ch_d;
      pend_div_q  <= pend_div_d;
      cfg_err_q   <= cfg_err_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign tick_o      = tick_q;
  assign sq_o        = sq_q;
  assign cfg_err_o   = cfg_err_q;
  assign cfg_ready_o = cfg_ready_q;

endmodule
